key_event_arbiter: RTL and testbench

KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

---
 rtl/key_event_arbiter_if.sv | 31 +++
 rtl/key_event_arbiter.sv | 111 +++++++++++
 tb/tb_key_event_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_arbiter_if.sv
// Key press / event handshake bundle between the debounce stage, the arbiter
// and the downstream event consumer.
interface key_event_arbiter_if;
  logic [3:0] key_pulse;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [3:0] pend;
  logic [7:0] drop_cnt;
  logic       busy;

  modport master (
    output key_pulse,
    output evt_ready,
    input  evt_valid,
    input  evt_code,
    input  pend,
    input  drop_cnt,
    input  busy
  );

  modport slave (
    input  key_pulse,
    input  evt_ready,
    output evt_valid,
    output evt_code,
    output pend,
    output drop_cnt,
    output busy
  );
endinterface

// File: rtl/key_event_arbiter.sv
// Round-robin arbiter turning 4 key press pulses into single handshaked events,
// with a post-event lockout period and a saturating count of lost presses.
module key_event_arbiter #(
  parameter logic [15:0] LOCK_CYC = 16'd1000
) (
  input  logic                 clk,
  input  logic                 rst,
  key_event_arbiter_if.slave   bus_io
);

  typedef enum logic [1:0] {StIdle, StPresent, StLock} state_e;

  state_e      state_q;
  logic [3:0]  pend_q, pend_d;
  logic        evt_valid_q;
  logic [1:0]  evt_code_q;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [15:0] lock_cnt_q;
  logic [1:0]  last_grant_q;

  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [3:0]  grant_clr;
  logic [3:0]  drop_bits;
  logic [2:0]  drop_num;
  logic [8:0]  drop_sum;

  // Upward search starting just past the previous winner.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found     = 1'b0;
    idx       = '0;
    grant_idx = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant_q + 2'(k);
      if (!found && pend_q[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end
    end
    grant_vld = (state_q == StIdle) && (pend_q != 4'b0000);
  end

  always_comb begin
    grant_clr  = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
    // A new press on a bit being granted this cycle re-arms it rather than dropping.
    pend_d     = (pend_q & ~grant_clr) | bus_io.key_pulse;
    drop_bits  = bus_io.key_pulse & pend_q & ~grant_clr;
    drop_num   = {2'b00, drop_bits[0]} + {2'b00, drop_bits[1]} +
                 {2'b00, drop_bits[2]} + {2'b00, drop_bits[3]};
    drop_sum   = {1'b0, drop_cnt_q} + {6'b000000, drop_num};
    drop_cnt_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      lock_cnt_q   <= '0;
      last_grant_q <= 2'd3;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_vld) begin
            evt_valid_q  <= 1'b1;
            evt_code_q   <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= StPresent;
          end
        end
        StPresent: begin
          if (bus_io.evt_ready) begin
            evt_valid_q <= 1'b0;
            lock_cnt_q  <= '0;
            state_q     <= (LOCK_CYC == 16'd0) ? StIdle : StLock;
          end
        end
        StLock: begin
          if (lock_cnt_q == LOCK_CYC - 16'd1) begin
            state_q <= StIdle;
          end else begin
            lock_cnt_q <= lock_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q     <= StIdle;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.evt_valid = evt_valid_q;
  assign bus_io.evt_code  = evt_code_q;
  assign bus_io.pend      = pend_q;
  assign bus_io.drop_cnt  = drop_cnt_q;
  assign bus_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scenario bench for key_event_arbiter: expected event codes are queued when
// presses are driven and matched against every accepted event.
module tb_key_event_arbiter;
  localparam logic [15:0] LockCyc = 16'd4;
  // One PRESENT cycle, LockCyc lock cycles, one IDLE grant cycle.
  localparam int EvtGap = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_event_arbiter_if bus ();

  key_event_arbiter #(
    .LOCK_CYC (LockCyc)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         n_acc  = 0;
  logic [1:0] exp_q[$];
  int         acc_cyc[$];
  logic [1:0] e_code;

  always @(posedge clk) cyc++;

  // Scoreboard: every accepted event must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
      checks++;
      n_acc++;
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL accept_unexpected: got code %0d, expected no event", bus.evt_code);
      end else begin
        e_code = exp_q.pop_front();
        if (bus.evt_code !== e_code) begin
          errors++;
          $display("FAIL accept_code: got %0d, expected %0d", bus.evt_code, e_code);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      if (bus.evt_valid === 1'b1) break;
      tick();
    end
    checks++;
    if (bus.evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_valid: evt_valid=%b after 100 cycles, expected 1", name, bus.evt_valid);
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      if (bus.busy === 1'b0 && bus.pend === 4'b0000 && bus.evt_valid === 1'b0) break;
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.pend !== 4'b0000) begin
      errors++;
      $display("FAIL %s_wait_idle: busy=%b pend=%b, expected 0 and 0000", name, bus.busy, bus.pend);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.key_pulse = 4'b0000;
    bus.evt_ready = 1'b0;
    tick(2);
    checks++;
    if ({bus.evt_valid, bus.evt_code, bus.pend, bus.drop_cnt, bus.busy} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: valid=%b code=%0d pend=%b drop=%0d busy=%b, expected all 0",
               bus.evt_valid, bus.evt_code, bus.pend, bus.drop_cnt, bus.busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.evt_ready = 1'b1;
    bus.key_pulse = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    bus.key_pulse = 4'b0000;
    checks++;
    if (bus.evt_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pend !== 4'b0100) begin
      errors++;
      $display("FAIL single_t1: valid=%b busy=%b pend=%b, expected 0 0 0100",
               bus.evt_valid, bus.busy, bus.pend);
    end
    tick();
    checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_code !== 2'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_t2: valid=%b code=%0d busy=%b, expected 1 2 1",
               bus.evt_valid, bus.evt_code, bus.busy);
    end
    for (int k = 3; k <= 6; k++) begin
      tick();
      checks++;
      if (bus.evt_valid !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_lock_t%0d: valid=%b busy=%b, expected 0 1", k, bus.evt_valid, bus.busy);
      end
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_t7: busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    test_reset();
    bus.evt_ready = 1'b1;
    base = acc_cyc.size();
    bus.key_pulse = 4'b1111;
    for (int k = 0; k < 4; k++) exp_q.push_back(2'(k));
    tick();
    bus.key_pulse = 4'b0000;
    wait_idle("simul");
    checks++;
    if (acc_cyc.size() - base !== 4) begin
      errors++;
      $display("FAIL simul_count: got %0d events, expected 4", acc_cyc.size() - base);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (acc_cyc[base+k] - acc_cyc[base+k-1] !== EvtGap) begin
          errors++;
          $display("FAIL simul_gap%0d: got %0d cycles, expected %0d", k,
                   acc_cyc[base+k] - acc_cyc[base+k-1], EvtGap);
        end
      end
    end
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL simul_drop: got %0d, expected 0", bus.drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int bad;
    bus.evt_ready = 1'b0;
    bus.key_pulse = 4'b1000;
    exp_q.push_back(2'd3);
    tick();
    bus.key_pulse = 4'b0000;
    wait_valid("bp");
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.evt_valid !== 1'b1 || bus.evt_code !== 2'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d cycles lost valid/code, expected 0 (valid=%b code=%0d)",
               bad, bus.evt_valid, bus.evt_code);
    end
    base = n_acc;
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
    checks++;
    if (bus.evt_valid !== 1'b0 || n_acc - base !== 1) begin
      errors++;
      $display("FAIL bp_accept: valid=%b accepts=%0d, expected 0 and 1", bus.evt_valid, n_acc - base);
    end
    wait_idle("bp");
  endtask

  task automatic test_drop_saturate();
    test_reset();
    bus.evt_ready = 1'b0;
    bus.key_pulse = 4'b0010;
    exp_q.push_back(2'd1);
    tick();
    bus.key_pulse = 4'b0000;
    wait_valid("drop");
    bus.key_pulse = 4'b0010;
    exp_q.push_back(2'd1);
    tick();
    checks++;
    if (bus.pend !== 4'b0010 || bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL drop_arm: pend=%b drop=%0d, expected 0010 0", bus.pend, bus.drop_cnt);
    end
    tick(3);
    bus.key_pulse = 4'b0000;
    tick();
    checks++;
    if (bus.drop_cnt !== 8'd3 || bus.pend !== 4'b0010) begin
      errors++;
      $display("FAIL drop_three: drop=%0d pend=%b, expected 3 0010", bus.drop_cnt, bus.pend);
    end
    bus.key_pulse = 4'b0010;
    tick(252);
    checks++;
    if (bus.drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_reach_max: got %0d, expected 255", bus.drop_cnt);
    end
    tick(48);
    bus.key_pulse = 4'b0000;
    tick();
    checks++;
    if (bus.drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d, expected 255", bus.drop_cnt);
    end
    bus.evt_ready = 1'b1;
    wait_idle("drop");
  endtask

  task automatic test_collision();
    int base;
    test_reset();
    bus.evt_ready = 1'b1;
    base = acc_cyc.size();
    bus.key_pulse = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    bus.key_pulse = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    bus.key_pulse = 4'b0000;
    checks++;
    if (bus.pend !== 4'b0001 || bus.drop_cnt !== 8'd0 || bus.evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL collide_state: pend=%b drop=%0d valid=%b, expected 0001 0 1",
               bus.pend, bus.drop_cnt, bus.evt_valid);
    end
    wait_idle("collide");
    checks++;
    if (acc_cyc.size() - base !== 2) begin
      errors++;
      $display("FAIL collide_count: got %0d events, expected 2", acc_cyc.size() - base);
    end else if (acc_cyc[base+1] - acc_cyc[base] !== EvtGap) begin
      errors++;
      $display("FAIL collide_gap: got %0d cycles, expected %0d",
               acc_cyc[base+1] - acc_cyc[base], EvtGap);
    end
  endtask

  task automatic test_reset_mid_lock();
    int base;
    int bad;
    test_reset();
    bus.evt_ready = 1'b1;
    bus.key_pulse = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    bus.key_pulse = 4'b0000;
    tick(2);
    bus.key_pulse = 4'b0011;
    tick();
    bus.key_pulse = 4'b0000;
    checks++;
    if (bus.pend !== 4'b0011 || bus.busy !== 1'b1 || bus.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rlock_pre: pend=%b busy=%b valid=%b, expected 0011 1 0",
               bus.pend, bus.busy, bus.evt_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.evt_valid, bus.evt_code, bus.pend, bus.drop_cnt, bus.busy} !== 16'h0000) begin
      errors++;
      $display("FAIL rlock_async: valid=%b code=%0d pend=%b drop=%0d busy=%b, expected all 0",
               bus.evt_valid, bus.evt_code, bus.pend, bus.drop_cnt, bus.busy);
    end
    tick();
    rst = 1'b0;
    base = n_acc;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.evt_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pend !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0 || n_acc != base) begin
      errors++;
      $display("FAIL rlock_quiet: %0d active cycles, %0d events, expected 0 0", bad, n_acc - base);
    end
    bus.key_pulse = 4'b0010;
    exp_q.push_back(2'd1);
    tick();
    bus.key_pulse = 4'b0000;
    tick();
    checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_code !== 2'd1) begin
      errors++;
      $display("FAIL rlock_first: valid=%b code=%0d, expected 1 1", bus.evt_valid, bus.evt_code);
    end
    wait_idle("rlock");
  endtask

  initial begin
    bus.key_pulse = 4'b0000;
    bus.evt_ready = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_drop_saturate();
    test_collision();
    test_reset_mid_lock();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
